// File: rtl/c499_stim_chk.sv
`default_nettype none
// ============================================================================
// Module : c499_stim_chk
// LFSR stimulus source with c499 check-bit encoding and a LAT-delayed checker.
// Rev    : 1.0  initial release
// ============================================================================
module c499_stim_chk #(
  parameter int          LAT   = 3,
  parameter logic [31:0] SEED  = 32'hACE10001,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             inj_en,
  input  logic [5:0]       inj_pos,
  output logic [31:0]      d_out,
  output logic [7:0]       c_out,
  output logic             en_out,
  input  logic [31:0]      qout_in,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam logic [31:0] c_seed = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int          c_dw   = (LAT < 2) ? 1 : $clog2(LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_lfsr;
  logic [CNT_W-1:0]  r_num_vec;
  logic              r_inj_en;
  logic [5:0]        r_inj_pos;
  logic [c_dw-1:0]   r_drain_cnt;
  logic [LAT-1:0]    r_pipe_vld;
  logic [31:0]       r_pipe_dat [LAT];
  logic [39:0]       w_flip;
  logic              w_start;
  logic              w_launch;
  logic              w_last;
  logic              w_cmp_fail;

  function automatic logic [7:0] calc_chk(input logic [31:0] d);
    logic [7:0] c;
    c[0] = (^d[23:16]) ^ d[0] ^ d[4] ^ d[8] ^ d[12];
    c[1] = (^d[31:24]) ^ d[1] ^ d[5] ^ d[9] ^ d[13];
    c[2] = (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
    c[3] = (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
    c[4] = (^d[7:0])   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
    c[5] = (^d[15:8])  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
    c[6] = (^d[3:0])   ^ (^d[11:8]) ^ d[18] ^ d[22] ^ d[26] ^ d[30];
    c[7] = (^d[7:4])   ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
    return c;
  endfunction

  assign w_start    = (r_state == S_IDLE) && start;
  assign w_launch   = (r_state == S_RUN);
  assign w_last     = ((vec_cnt + CNT_W'(1)) == r_num_vec);
  assign w_cmp_fail = r_pipe_vld[LAT-1] && (qout_in != r_pipe_dat[LAT-1]);
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);

  // Positions 40..63 select no bit, leaving the vector uncorrupted.
  always_comb begin
    w_flip = '0;
    if (r_inj_en && (r_inj_pos < 6'd40)) begin
      w_flip[r_inj_pos] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (num_vec != '0) ? S_RUN : S_DRAIN;
      S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == c_dw'(LAT - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= c_seed;
      r_num_vec   <= '0;
      r_inj_en    <= 1'b0;
      r_inj_pos   <= '0;
      r_drain_cnt <= '0;
      d_out       <= '0;
      c_out       <= '0;
      en_out      <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= '0;
      vec_cnt     <= '0;
      r_pipe_vld  <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pipe_dat[i] <= '0;
      end
    end else begin
      d_out    <= '0;
      c_out    <= '0;
      en_out   <= 1'b0;
      mismatch <= w_cmp_fail;

      if (w_start) begin
        r_num_vec <= num_vec;
        r_inj_en  <= inj_en;
        r_inj_pos <= inj_pos;
        vec_cnt   <= '0;
        err_cnt   <= '0;
      end

      // en_out travels with d_out/c_out so the DUT sees them on the same edge.
      if (w_launch) begin
        d_out   <= r_lfsr ^ w_flip[31:0];
        c_out   <= calc_chk(r_lfsr) ^ w_flip[39:32];
        en_out  <= 1'b1;
        r_lfsr  <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
        vec_cnt <= vec_cnt + CNT_W'(1);
      end

      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + c_dw'(1);
      end else begin
        r_drain_cnt <= '0;
      end

      // Reference carries the uncorrupted word: the SEC stage is expected to undo any flip.
      r_pipe_vld[0] <= w_launch;
      r_pipe_dat[0] <= r_lfsr;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
      end

      if (w_cmp_fail && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c499_stim_chk.sv
`default_nettype none
// ============================================================================
// Module : tb_c499_stim_chk
// Scoreboard bench: c499_stim_chk looped through a registered c499 SEC model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_c499_stim_chk;

  localparam int          LAT   = 3;
  localparam int          CNT_W = 16;
  localparam logic [31:0] SEED  = 32'hACE10001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             inj_en = 1'b0;
  logic [5:0]       inj_pos = '0;
  logic [31:0]      d_out;
  logic [7:0]       c_out;
  logic             en_out;
  logic [31:0]      qout_in;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;

  c499_stim_chk #(.LAT(LAT), .SEED(SEED), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .inj_en(inj_en), .inj_pos(inj_pos), .d_out(d_out), .c_out(c_out),
    .en_out(en_out), .qout_in(qout_in), .busy(busy), .done(done),
    .mismatch(mismatch), .err_cnt(err_cnt), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  // Parity masks written out from the c499 check equations.
  function automatic logic [7:0] p_ref(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^(d & 32'h00FF1111);
    c[1] = ^(d & 32'hFF002222);
    c[2] = ^(d & 32'h0F0F4444);
    c[3] = ^(d & 32'hF0F08888);
    c[4] = ^(d & 32'h111100FF);
    c[5] = ^(d & 32'h2222FF00);
    c[6] = ^(d & 32'h44440F0F);
    c[7] = ^(d & 32'h8888F0F0);
    return c;
  endfunction

  function automatic logic [31:0] sec_fix(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  s;
    logic [31:0] r;
    s = p_ref(d) ^ c;
    r = d;
    for (int i = 0; i < 32; i++) begin
      if (s != 8'h0 && p_ref(32'h1 << i) == s) r[i] = ~r[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Registered SEC wrapper model: input FFs, correction, output FFs (launch + 3 = sample).
  logic [31:0] m_d, m_q;
  logic [7:0]  m_c;
  logic        stuck7 = 1'b0;
  always @(posedge clk) begin
    m_d <= d_out;
    m_c <= c_out;
    m_q <= sec_fix(m_d, m_c) | (stuck7 ? 32'h80 : 32'h0);
  end
  assign qout_in = m_q;

  typedef struct packed { logic [31:0] d; logic [7:0] c; } vec_t;
  typedef struct packed { logic [CNT_W-1:0] err; logic [CNT_W-1:0] vec; } res_t;
  vec_t        exp_q[$];
  res_t        res_q[$];
  vec_t        mon_v;
  res_t        mon_r;
  logic [31:0] mdl_l;
  int          tests = 0;
  int          fails = 0;
  int          mm_seen = 0;
  int          bcnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_run(input int n, input bit ie, input int ip, input bit stuck);
    vec_t v;
    res_t r;
    int   e;
    e = 0;
    for (int i = 0; i < n; i++) begin
      v.d = mdl_l;
      v.c = p_ref(mdl_l);
      if (ie && ip < 32) v.d[ip] = ~v.d[ip];
      else if (ie && ip < 40) v.c[ip-32] = ~v.c[ip-32];
      exp_q.push_back(v);
      if (stuck && !mdl_l[7]) e++;
      mdl_l = lfsr_next(mdl_l);
    end
    r.err = CNT_W'(e);
    r.vec = CNT_W'(n);
    res_q.push_back(r);
  endtask

  task automatic start_run(input int n, input bit ie, input int ip);
    num_vec = CNT_W'(n);
    inj_en  = ie;
    inj_pos = 6'(ip);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int max, output int busy_n);
    bit got;
    int k;
    got = 1'b0;
    busy_n = 0;
    k = 0;
    while (!got && k < max) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_n++;
        tick();
        k++;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", max);
    end
    tick();
  endtask

  // Monitor: launches checked against exp_q, run results against res_q.
  always @(negedge clk) begin
    if (!rst_n) begin
      mm_seen = 0;
    end else begin
      if (mismatch) mm_seen++;
      if (en_out) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_launch: got d=%h c=%h, required no launch", d_out, c_out);
        end else begin
          mon_v = exp_q.pop_front();
          if ({d_out, c_out} !== {mon_v.d, mon_v.c}) begin
            fails++;
            $display("FAIL launch: got d=%h c=%h expected d=%h c=%h", d_out, c_out, mon_v.d, mon_v.c);
          end
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done, required none");
        end else begin
          mon_r = res_q.pop_front();
          chk("err_cnt", 64'(err_cnt), 64'(mon_r.err));
          chk("vec_cnt", 64'(vec_cnt), 64'(mon_r.vec));
          chk("mismatch_pulses", 64'(mm_seen), 64'(mon_r.err));
        end
        mm_seen = 0;
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_d_out", 64'(d_out), 64'h0);
    chk("rst_c_out", 64'(c_out), 64'h0);
    chk("rst_ctrl", 64'({en_out, busy, done, mismatch}), 64'h0);
    chk("rst_cnt", 64'({err_cnt, vec_cnt}), 64'h0);
    rst_n = 1'b1;
    mdl_l = SEED;
    tick();

    // single vector: seed word and its hand-computed check bits
    push_run(1, 1'b0, 0, 1'b0);
    start_run(1, 1'b0, 0);
    tick();
    chk("t1_d_out", 64'(d_out), 64'hACE10001);
    chk("t1_c_out", 64'(c_out), 64'hCD);
    chk("t1_en_out", 64'(en_out), 64'h1);
    wait_done(20, bcnt);

    // data bit 5 flipped on every vector; first word is 59C20003 ^ 0x20
    push_run(1000, 1'b1, 5, 1'b0);
    start_run(1000, 1'b1, 5);
    tick();
    chk("t2_d_out", 64'(d_out), 64'h59C20023);
    chk("t2_c_out", 64'(c_out), 64'h26);
    wait_done(1100, bcnt);

    // check bit 3 flipped
    push_run(200, 1'b1, 35, 1'b0);
    start_run(200, 1'b1, 35);
    wait_done(300, bcnt);

    // faulty DUT: Qout bit7 stuck at 1
    stuck7 = 1'b1;
    push_run(64, 1'b0, 0, 1'b1);
    start_run(64, 1'b0, 0);
    wait_done(200, bcnt);
    stuck7 = 1'b0;

    // empty run
    push_run(0, 1'b0, 0, 1'b0);
    start_run(0, 1'b0, 0);
    wait_done(20, bcnt);
    chk("t5_busy_cycles", 64'(bcnt), 64'(LAT));

    // reset at vector 10 of 50
    push_run(50, 1'b0, 0, 1'b0);
    start_run(50, 1'b0, 0);
    for (int k = 0; k < 100 && vec_cnt != CNT_W'(10); k++) tick();
    chk("t6_reach_vec10", 64'(vec_cnt), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_d_out", 64'(d_out), 64'h0);
    chk("t6_rst_c_out", 64'(c_out), 64'h0);
    chk("t6_rst_ctrl", 64'({en_out, busy, done, mismatch}), 64'h0);
    chk("t6_rst_cnt", 64'({err_cnt, vec_cnt}), 64'h0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    res_q.delete();
    mdl_l = SEED;
    tick();
    push_run(1, 1'b0, 0, 1'b0);
    start_run(1, 1'b0, 0);
    tick();
    chk("t6_seed_d_out", 64'(d_out), 64'hACE10001);
    chk("t6_seed_c_out", 64'(c_out), 64'hCD);
    wait_done(20, bcnt);

    // start pulse with new parameters while running must be ignored
    push_run(20, 1'b0, 0, 1'b0);
    start_run(20, 1'b0, 0);
    repeat (5) tick();
    num_vec = CNT_W'(5);
    inj_en  = 1'b1;
    inj_pos = 6'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_done(100, bcnt);
    chk("t6_busy_after_run", 64'(busy), 64'h0);

    repeat (4) tick();
    chk("scoreboard_drained", 64'(exp_q.size() + res_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
